// File: rtl/ccff_readback_capture.sv
// Captures the serial config-chain tail into MSB-first 32-bit words behind a small FIFO.
// Latency: word_valid_o rises one cycle after the strobe that completes a word.
// Backpressure: valid/ready at the output; a push into a full FIFO is dropped and flagged.
// Optional build macro CCFF_READBACK_CRC_EN adds a serial CRC-32 over every sampled bit.

// Generic synchronous FIFO with registered storage and a combinational head.
// Latency: a pushed entry is visible at rd_dat one cycle after the push.
// Backpressure: wr_rdy drops when full unless a pop happens in the same cycle.
module fifo_sync #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_vld,
  output logic         wr_rdy,
  input  logic [W-1:0] wr_dat,
  output logic         rd_vld,
  input  logic         rd_rdy,
  output logic [W-1:0] rd_dat
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          push;
  logic          pop;

  assign rd_vld = (cnt != '0);
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign wr_rdy = (cnt != FULL_CNT) || rd_rdy;
  assign push   = wr_vld && wr_rdy;
  assign pop    = rd_vld && rd_rdy;
  assign rd_dat = mem[rd_ptr];

  // Storage, pointers (wrap naturally at power-of-2 depth) and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// Receive end of the configuration chain: bit sampler, word packer, FIFO and control FSM.
// Latency: one cycle from the completing shift_en_i strobe to word_valid_o.
// Backpressure: consumer stalls hold word_o/last_o; overflowing words are dropped, overflow_o sticks.
module ccff_readback_capture #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [CNT_W-1:0] bit_count_i,
  input  logic             shift_en_i,
  input  logic             ccff_tail_i,
  output logic [31:0]      word_o,
  output logic             word_valid_o,
  input  logic             word_ready_i,
  output logic             last_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             overflow_o,
  output logic [CNT_W-1:0] bits_captured_o
`ifdef CCFF_READBACK_CRC_EN
  ,
  output logic [31:0]      crc_o,
  output logic             crc_valid_o
`endif
);
  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_FLUSH, S_DONE} state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] bits_q;
  logic [CNT_W-1:0] bits_next;
  logic [31:0]      sr_q;
  logic [31:0]      word_full;
  logic [31:0]      word_final;
  logic [4:0]       pad_shamt;
  logic             overflow_q;
  logic             start_ok;
  logic             sample;
  logic             final_bit;
  logic             push_vld;
  logic             push_rdy;
  logic [32:0]      push_dat;
  logic             fifo_vld;
  logic [32:0]      fifo_dat;

  assign start_ok  = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign sample    = shift_en_i && (state_q == S_CAPTURE);
  assign bits_next = bits_q + 1'b1;
  assign final_bit = sample && (bits_next == count_q);
  assign word_full = {sr_q[30:0], ccff_tail_i};
  // bits_q[4:0] is the position of the incoming bit inside its word, so a
  // partial final word of n bits needs a left shift of 32-n = 31-position.
  assign pad_shamt  = 5'd31 - bits_q[4:0];
  assign word_final = word_full << pad_shamt;
  assign push_vld   = sample && (final_bit || (bits_q[4:0] == 5'd31));
  assign push_dat   = {final_bit, final_bit ? word_final : word_full};

  fifo_sync #(
    .W     (33),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_vld (push_vld),
    .wr_rdy (push_rdy),
    .wr_dat (push_dat),
    .rd_vld (fifo_vld),
    .rd_rdy (word_ready_i),
    .rd_dat (fifo_dat)
  );

  assign word_valid_o    = fifo_vld;
  assign word_o          = fifo_vld ? fifo_dat[31:0] : 32'h0;
  assign last_o          = fifo_vld && fifo_dat[32];
  assign overflow_o      = overflow_q;
  assign bits_captured_o = bits_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and status outputs; a zero-length capture goes straight to DONE.
  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        done_o = (state_q == S_DONE);
        if (start_i) state_d = (bit_count_i == '0) ? S_DONE : S_CAPTURE;
      end
      S_CAPTURE: begin
        busy_o = 1'b1;
        if (final_bit) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        busy_o = 1'b1;
        if (!fifo_vld) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Capture datapath: latch length on start, shift and count on each accepted strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      bits_q  <= '0;
      sr_q    <= '0;
    end else if (start_ok) begin
      count_q <= bit_count_i;
      bits_q  <= '0;
      sr_q    <= '0;
    end else if (sample) begin
      sr_q    <= word_full;
      bits_q  <= bits_next;
    end
  end

  // Sticky drop flag: set when a word meets a full FIFO with no pop that cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      overflow_q <= 1'b0;
    else if (start_ok)              overflow_q <= 1'b0;
    else if (push_vld && !push_rdy) overflow_q <= 1'b1;
  end

`ifdef CCFF_READBACK_CRC_EN
  localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;

  logic [31:0] crc_q;
  logic [31:0] crc_next;
  logic        crc_fb;

  // MSB-first serial CRC step; covers every sampled bit, dropped words included.
  always_comb begin
    crc_fb   = crc_q[31] ^ ccff_tail_i;
    crc_next = {crc_q[30:0], 1'b0} ^ (crc_fb ? CRC_POLY : 32'h0);
  end

  // CRC register seeded with all ones on reset and on every accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         crc_q <= 32'hFFFF_FFFF;
    else if (start_ok) crc_q <= 32'hFFFF_FFFF;
    else if (sample)   crc_q <= crc_next;
  end

  assign crc_o       = ~crc_q;
  assign crc_valid_o = (state_q == S_DONE);
`endif
endmodule
